// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - mode encodings shared by the flip-flop bank and its cells
package ff_bank_pkg;

  typedef enum logic [1:0] {
    FF_D  = 2'b00,
    FF_T  = 2'b01,
    FF_JK = 2'b10,
    FF_SR = 2'b11
  } ff_mode_t;

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - one storage bit with selectable D/T/JK/SR behaviour
import ff_bank_pkg::*;

module ff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  ff_mode_t mode,
  input  logic     a,
  input  logic     b,
  output logic     q,
  output logic     q_n,
  output logic     q_next,
  output logic     illegal
);

  // Next-state selection; an S=R=1 request holds the bit and is flagged.
  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    if (en) begin
      case (mode)
        FF_D:  q_next = a;
        FF_T:  q_next = q ^ a;
        FF_JK: begin
          case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        FF_SR: begin
          case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   illegal = 1'b1;
            default: q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end
  end

  // State register; the complement is registered too so q_n never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_BIT;
      q_n <= ~RST_BIT;
    end else begin
      q   <= q_next;
      q_n <= ~q_next;
    end
  end

endmodule

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - WIDTH-bit flip-flop bank with change flags, SR error and event counter
import ff_bank_pkg::*;

module ff_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  ff_mode_t         mode_e;

  assign mode_e = ff_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode_e),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .q_n     (q_n[i]),
      .q_next  (q_next[i]),
      .illegal (illegal[i])
    );
  end

  // Change flags and SR error; both clear on a held edge since q_next equals q there.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= '0;
      err     <= 1'b0;
    end else begin
      changed <= q_next ^ q;
      err     <= |illegal;
    end
  end

  // Count edges on which any bit moved, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (en && (q_next != q) && (chg_cnt != CNT_MAX)) begin
      chg_cnt <= chg_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ff_bank.sv
// tb/tb_ff_bank.sv - self-checking bench for ff_bank with directed and random stimulus
module tb_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;

  logic [7:0]  q, q_n, changed;
  logic        err;
  logic [15:0] chg_cnt;

  logic [7:0]  qs, qs_n, changed_s;
  logic        err_s;
  logic [1:0]  chg_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .q(q), .q_n(q_n), .changed(changed), .err(err), .chg_cnt(chg_cnt)
  );

  ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .q(qs), .q_n(qs_n), .changed(changed_s), .err(err_s), .chg_cnt(chg_cnt_s)
  );

  // Reference next state written as set/clear/toggle masks over the whole word.
  function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] cur,
                                            input logic [7:0] x, input logic [7:0] y);
    logic [7:0] set_m, clr_m, tog_m;
    case (m)
      2'd0: return x;
      2'd1: return cur ^ x;
      2'd2: begin
        set_m = x & ~y;
        clr_m = ~x & y;
        tog_m = x & y;
        return ((cur ^ tog_m) | set_m) & ~clr_m;
      end
      default: begin
        set_m = x & ~y;
        clr_m = ~x & y;
        return (cur | set_m) & ~clr_m;
      end
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] x, input logic [7:0] y);
    rst = r; en = e; mode = m; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", q); end
    checks++; if (q_n !== 8'h5A) begin errors++; $display("FAIL reset_qn got %h exp 5a", q_n); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL reset_changed got %h exp 00", changed); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", chg_cnt); end
    step(1'b1, 1'b1, 2'd0, 8'hFF, 8'h00);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_hold_q got %h exp a5", q); end
  endtask

  task automatic test_d_then_t;
    step(1'b0, 1'b1, 2'd0, 8'h3C, 8'h00);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL d_q got %h exp 3c", q); end
    checks++; if (changed !== 8'h99) begin errors++; $display("FAIL d_changed got %h exp 99", changed); end
    checks++; if (chg_cnt !== 16'd1) begin errors++; $display("FAIL d_cnt got %0d exp 1", chg_cnt); end
    step(1'b0, 1'b1, 2'd1, 8'h0F, 8'h00);
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL t_q got %h exp 33", q); end
    checks++; if (changed !== 8'h0F) begin errors++; $display("FAIL t_changed got %h exp 0f", changed); end
    checks++; if (chg_cnt !== 16'd2) begin errors++; $display("FAIL t_cnt got %0d exp 2", chg_cnt); end
    step(1'b0, 1'b0, 2'd0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL hold_q got %h exp 33", q); end
    checks++; if (changed !== 8'h00) begin errors++; $display("FAIL hold_changed got %h exp 00", changed); end
    checks++; if (chg_cnt !== 16'd2) begin errors++; $display("FAIL hold_cnt got %0d exp 2", chg_cnt); end
  endtask

  task automatic test_jk;
    step(1'b0, 1'b1, 2'd0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 2'd2, 8'hF0, 8'hCC);
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL jk1_q got %h exp f0", q); end
    step(1'b0, 1'b1, 2'd2, 8'hF0, 8'hCC);
    checks++; if (q !== 8'h30) begin errors++; $display("FAIL jk2_q got %h exp 30", q); end
    checks++; if (q_n !== 8'hCF) begin errors++; $display("FAIL jk2_qn got %h exp cf", q_n); end
  endtask

  task automatic test_sr_illegal;
    step(1'b0, 1'b1, 2'd0, 8'h0F, 8'h00);
    step(1'b0, 1'b1, 2'd3, 8'h81, 8'h01);
    checks++; if (q !== 8'h8F) begin errors++; $display("FAIL sr_q got %h exp 8f", q); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sr_err got %b exp 1", err); end
    checks++; if (changed !== 8'h80) begin errors++; $display("FAIL sr_changed got %h exp 80", changed); end
    step(1'b0, 1'b1, 2'd3, 8'h81, 8'h00);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sr_err_clear got %b exp 0", err); end
    checks++; if (q !== 8'h8F) begin errors++; $display("FAIL sr_q2 got %h exp 8f", q); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_bit;
    step(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    exp_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
      exp_bit = ~exp_bit;
      checks++; if (chg_cnt_s !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, chg_cnt_s, exp_cnt[i]); end
      checks++; if (qs[0] !== exp_bit) begin errors++; $display("FAIL sat_q0[%0d] got %b exp %b", i, qs[0], exp_bit); end
      checks++; if (changed_s !== 8'h01) begin errors++; $display("FAIL sat_changed[%0d] got %h exp 01", i, changed_s); end
    end
    step(1'b1, 1'b1, 2'd1, 8'h01, 8'h00);
    checks++; if (chg_cnt_s !== 2'd0) begin errors++; $display("FAIL sat_rst_cnt got %0d exp 0", chg_cnt_s); end
    step(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    checks++; if (qs !== 8'h01) begin errors++; $display("FAIL sat_after_rst_q got %h exp 01", qs); end
  endtask

  task automatic test_random;
    logic [7:0]  mq, mchg, ms, mchg_s, nq;
    logic        merr;
    int unsigned mcnt, mcnt_s;
    logic        r, e;
    logic [1:0]  m;
    logic [7:0]  x, y;
    step(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    mq = 8'hA5; ms = 8'h00; mcnt = 0; mcnt_s = 0;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = 8'($urandom);
      step(r, e, m, x, y);
      if (r) begin
        mq = 8'hA5; ms = 8'h00; mchg = 8'h00; mchg_s = 8'h00; merr = 1'b0; mcnt = 0; mcnt_s = 0;
      end else if (!e) begin
        mchg = 8'h00; mchg_s = 8'h00; merr = 1'b0;
      end else begin
        merr = (m == 2'd3) && ((x & y) != 8'h00);
        nq = model_next(m, mq, x, y);
        mchg = nq ^ mq;
        if (nq != mq && mcnt < 65535) mcnt++;
        mq = nq;
        nq = model_next(m, ms, x, y);
        mchg_s = nq ^ ms;
        if (nq != ms && mcnt_s < 3) mcnt_s++;
        ms = nq;
      end
      checks++; if (q !== mq || q_n !== ~mq) begin errors++; $display("FAIL rnd_q[%0d] got %h/%h exp %h", i, q, q_n, mq); end
      checks++; if (changed !== mchg) begin errors++; $display("FAIL rnd_changed[%0d] got %h exp %h", i, changed, mchg); end
      checks++; if (err !== merr || err_s !== merr) begin errors++; $display("FAIL rnd_err[%0d] got %b/%b exp %b", i, err, err_s, merr); end
      checks++; if (chg_cnt !== 16'(mcnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, chg_cnt, mcnt); end
      checks++; if (qs !== ms || changed_s !== mchg_s || chg_cnt_s !== 2'(mcnt_s)) begin
        errors++; $display("FAIL rnd_sat[%0d] got q=%h chg=%h cnt=%0d exp q=%h chg=%h cnt=%0d", i, qs, changed_s, chg_cnt_s, ms, mchg_s, mcnt_s);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00;
    test_reset;
    test_d_then_t;
    test_jk;
    test_sr_illegal;
    test_saturation;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
